// File: rtl/dcache_nway_wb_if.sv
// dcache_nway_wb_if: datapath and memory-controller signals of dcache_nway_wb.
// Handshake: the datapath holds dmemREN/dmemWEN, dmemaddr and dmemstore stable
// until the cache answers with dhit; the cache holds dREN/dWEN, daddr and dstore
// stable while dwait=1, and one word moves on each cycle with dREN|dWEN=1 and
// dwait=0.
interface dcache_nway_wb_if;
    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;

    // Cache side.
    modport slave (
        input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    // Datapath / memory side.
    modport master (
        output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_nway_wb.sv
// dcache_nway_wb: parametrised write-back, write-allocate data cache with true
// LRU over WAYS ways, invalid-way-first victims and a full dirty flush on halt.
// Optional macro DCACHE_STATS_EN: adds 32-bit hit/miss counters that are
// written to STAT_ADDR and STAT_ADDR+4 after the flush.
module dcache_nway_wb #(
    parameter int          SETS      = 8,
    parameter int          WAYS      = 2,
    parameter int          BLK_WORDS = 2
`ifdef DCACHE_STATS_EN
    ,
    parameter logic [31:0] STAT_ADDR = 32'h3100
`endif
) (
    input  logic            CLK,
    input  logic            n_rst,
    dcache_nway_wb_if.slave bus,
    output logic [2:0]      o_dbg_state
);
    localparam int IW  = $clog2(SETS);
    localparam int OW  = $clog2(BLK_WORDS);
    localparam int WW  = $clog2(WAYS);
    localparam int OWC = (OW > 0) ? OW : 1;
    localparam int AWC = (WW > 0) ? WW : 1;
    localparam int TW  = 30 - IW - OW;
    localparam logic [OWC-1:0] LAST_W   = OWC'(BLK_WORDS - 1);
    localparam logic [AWC-1:0] LAST_WAY = AWC'(WAYS - 1);
    localparam logic [IW-1:0]  LAST_SET = IW'(SETS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB    = 3'd1,
        S_FILL  = 3'd2,
        S_FSCAN = 3'd3,
        S_FWB   = 3'd4,
`ifdef DCACHE_STATS_EN
        S_STAT  = 3'd5,
`endif
        S_DONE  = 3'd6
    } state_t;

`ifdef DCACHE_STATS_EN
    localparam state_t FLUSH_END = S_STAT;
`else
    localparam state_t FLUSH_END = S_DONE;
`endif

    // Frame storage and per-set ages (0 = most recently used).
    logic           r_valid [SETS][WAYS];
    logic           r_dirty [SETS][WAYS];
    logic [AWC-1:0] r_age   [SETS][WAYS];
    logic [TW-1:0]  r_tag   [SETS][WAYS];
    logic [31:0]    r_data  [SETS][WAYS][BLK_WORDS];

    state_t         r_state;
    logic [OWC-1:0] r_cnt;
    logic [IW-1:0]  r_ridx;
    logic [TW-1:0]  r_rtag;
    logic [AWC-1:0] r_vway;
    logic [IW-1:0]  r_fset;
    logic [AWC-1:0] r_fway;

    logic [TW-1:0]  w_tag;
    logic [IW-1:0]  w_idx;
    logic [OWC-1:0] w_off;
    logic           w_hit_any, w_hit, w_miss, w_fill_done, w_flast, w_touch;
    logic [AWC-1:0] w_hway, w_vict, w_tway;
    logic [IW-1:0]  w_tset;

`ifdef DCACHE_STATS_EN
    logic [31:0]    r_hits, r_misses;
    logic           r_replay, r_stat_sel;
`endif

    function automatic logic [31:0] mk_addr(input logic [TW-1:0] t,
                                            input logic [IW-1:0] i,
                                            input logic [OWC-1:0] o);
        return (32'(t) << (IW + OW + 2)) | (32'(i) << (OW + 2)) | (32'(o) << 2);
    endfunction

    assign w_tag = bus.dmemaddr[31 -: TW];
    assign w_idx = bus.dmemaddr[2 + OW +: IW];
    if (OW > 0) begin : g_off
        assign w_off = bus.dmemaddr[2 +: OWC];
    end else begin : g_no_off
        assign w_off = '0;
    end

    // Tag compare across the ways of the addressed set.
    always_comb begin
        w_hit_any = 1'b0;
        w_hway    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit_any = 1'b1;
                w_hway    = AWC'(w);
            end
        end
    end

    // Victim: lowest-numbered invalid way, otherwise the oldest way.
    always_comb begin
        logic found;
        found  = 1'b0;
        w_vict = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                found  = 1'b1;
                w_vict = AWC'(w);
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[w_idx][w] == LAST_WAY) w_vict = AWC'(w);
            end
        end
    end

    // A halt in IDLE takes priority, so no access is looked at that cycle.
    assign w_hit       = (r_state == S_IDLE) && !bus.halt && (bus.dmemREN || bus.dmemWEN) && w_hit_any;
    assign w_miss      = (r_state == S_IDLE) && !bus.halt && (bus.dmemREN || bus.dmemWEN) && !w_hit_any;
    assign w_fill_done = (r_state == S_FILL) && !bus.dwait && (r_cnt == LAST_W);
    assign w_flast     = (r_fset == LAST_SET) && (r_fway == LAST_WAY);
    assign w_touch     = w_hit || w_fill_done;
    assign w_tset      = w_fill_done ? r_ridx : w_idx;
    assign w_tway      = w_fill_done ? r_vway : w_hway;

    assign bus.dhit     = w_hit;
    assign bus.dmemload = (w_hit && bus.dmemREN) ? r_data[w_idx][w_hway][w_off] : 32'd0;
    assign bus.flushed  = (r_state == S_DONE);
    assign bus.dREN     = (r_state == S_FILL);
`ifdef DCACHE_STATS_EN
    assign bus.dWEN     = (r_state == S_WB) || (r_state == S_FWB) || (r_state == S_STAT);
`else
    assign bus.dWEN     = (r_state == S_WB) || (r_state == S_FWB);
`endif
    assign o_dbg_state  = r_state;

    // Memory address and write data decoded from the registered state.
    always_comb begin
        bus.daddr  = 32'd0;
        bus.dstore = 32'd0;
        case (r_state)
            S_WB: begin
                bus.daddr  = mk_addr(r_tag[r_ridx][r_vway], r_ridx, r_cnt);
                bus.dstore = r_data[r_ridx][r_vway][r_cnt];
            end
            S_FILL: bus.daddr = mk_addr(r_rtag, r_ridx, r_cnt);
            S_FWB: begin
                bus.daddr  = mk_addr(r_tag[r_fset][r_fway], r_fset, r_cnt);
                bus.dstore = r_data[r_fset][r_fway][r_cnt];
            end
`ifdef DCACHE_STATS_EN
            S_STAT: begin
                bus.daddr  = r_stat_sel ? (STAT_ADDR + 32'd4) : STAT_ADDR;
                bus.dstore = r_stat_sel ? r_misses : r_hits;
            end
`endif
            default: ;
        endcase
    end

    // Control FSM plus valid/dirty bits; reset aborts any transfer in flight.
    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ridx  <= '0;
            r_rtag  <= '0;
            r_vway  <= '0;
            r_fset  <= '0;
            r_fway  <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.halt) begin
                        r_state <= S_FSCAN;
                        r_fset  <= '0;
                        r_fway  <= '0;
                    end else if (w_hit) begin
                        if (bus.dmemWEN) r_dirty[w_idx][w_hway] <= 1'b1;
                    end else if (w_miss) begin
                        r_ridx  <= w_idx;
                        r_rtag  <= w_tag;
                        r_vway  <= w_vict;
                        r_cnt   <= '0;
                        r_state <= (r_valid[w_idx][w_vict] && r_dirty[w_idx][w_vict]) ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (!bus.dwait) begin
                        if (r_cnt == LAST_W) begin
                            r_cnt   <= '0;
                            r_state <= S_FILL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (!bus.dwait) begin
                        if (r_cnt == LAST_W) begin
                            r_cnt                 <= '0;
                            r_valid[r_ridx][r_vway] <= 1'b1;
                            r_dirty[r_ridx][r_vway] <= 1'b0;
                            r_state               <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_FSCAN: begin
                    if (r_dirty[r_fset][r_fway]) begin
                        r_cnt   <= '0;
                        r_state <= S_FWB;
                    end else begin
                        r_valid[r_fset][r_fway] <= 1'b0;
                        if (w_flast) begin
                            r_state <= FLUSH_END;
                        end else if (r_fway == LAST_WAY) begin
                            r_fway <= '0;
                            r_fset <= r_fset + 1'b1;
                        end else begin
                            r_fway <= r_fway + 1'b1;
                        end
                    end
                end
                S_FWB: begin
                    if (!bus.dwait) begin
                        if (r_cnt == LAST_W) begin
                            r_cnt                   <= '0;
                            r_dirty[r_fset][r_fway] <= 1'b0;
                            r_valid[r_fset][r_fway] <= 1'b0;
                            if (w_flast) begin
                                r_state <= FLUSH_END;
                            end else begin
                                r_state <= S_FSCAN;
                                if (r_fway == LAST_WAY) begin
                                    r_fway <= '0;
                                    r_fset <= r_fset + 1'b1;
                                end else begin
                                    r_fway <= r_fway + 1'b1;
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef DCACHE_STATS_EN
                S_STAT: begin
                    if (!bus.dwait && r_stat_sel) r_state <= S_DONE;
                end
`endif
                default: r_state <= S_DONE;
            endcase
        end
    end

    // True LRU: the touched way becomes 0, younger ways age by one.
    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) r_age[s][w] <= AWC'(w);
            end
        end else if (w_touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AWC'(w) == w_tway) r_age[w_tset][w] <= '0;
                else if (r_age[w_tset][w] < r_age[w_tset][w_tway]) r_age[w_tset][w] <= r_age[w_tset][w] + 1'b1;
            end
        end
    end

    // Data words and tags need no reset; valid bits guard them.
    always_ff @(posedge CLK) begin
        if (w_hit && bus.dmemWEN) r_data[w_idx][w_hway][w_off] <= bus.dmemstore;
        if (r_state == S_FILL && !bus.dwait) r_data[r_ridx][r_vway][r_cnt] <= bus.dload;
        if (w_fill_done) r_tag[r_ridx][r_vway] <= r_rtag;
    end

`ifdef DCACHE_STATS_EN
    // Hit/miss counters; the hit that replays a just-filled miss is not counted.
    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            r_hits     <= '0;
            r_misses   <= '0;
            r_replay   <= 1'b0;
            r_stat_sel <= 1'b0;
        end else begin
            if (w_hit && !r_replay) r_hits <= r_hits + 32'd1;
            if (w_miss) r_misses <= r_misses + 32'd1;
            if (w_fill_done) r_replay <= 1'b1;
            else if (r_state == S_IDLE) r_replay <= 1'b0;
            if (r_state == S_STAT && !bus.dwait) r_stat_sel <= 1'b1;
        end
    end
`endif
endmodule
